// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and a one-entry
// valid/ready holding register. Line errors are single-cycle pulses and never stall reception.
module uart_rx #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned HALF_BIT    = CLK_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun
);
    localparam int unsigned   CW        = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          r_sync1;
    logic          r_rx_s;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_ovr;
    logic          w_tick;

    assign w_tick        = (r_cnt == '0);
    assign data          = r_data;
    assign valid         = r_valid;
    assign framing_error = r_ferr;
    assign overrun       = r_ovr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (r_valid && ready)
                r_valid <= 1'b0;
            if (r_state != IDLE)
                r_cnt <= w_tick ? FULL_LOAD : r_cnt - CW'(1);

            unique case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        r_cnt   <= HALF_LOAD;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_bit_idx <= '0;
                            r_state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == 3'd7)
                            r_state <= STOP;
                        else
                            r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        // A load overrides the consume-clear above, so a same-edge drain keeps valid high.
                        if (!r_rx_s) begin
                            r_ferr <= 1'b1;
                        end else if (!r_valid || ready) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames, checked against
// a frame-level model (fixed start-edge-to-output latency, one-entry holding register).
module tb_uart_rx;
    localparam int unsigned CPB  = 200;
    localparam int unsigned HALF = CPB / 2;
    localparam int          LAT  = 3 + int'(HALF) + 9 * int'(CPB);

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun;

    uart_rx #(.CLK_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clk(clk), .reset(reset), .rx(rx), .data(data), .valid(valid),
        .ready(ready), .framing_error(framing_error), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         done;
        logic [7:0] d;
        logic       stop;
    } frame_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_fe = 0;
    int         n_ov = 0;
    int         last_done = 0;
    bit         rand_rdy = 1'b0;
    frame_t     pend[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic       rdy_edge = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Each frame resolves exactly LAT edges after its start edge was driven on the pin.
    always @(negedge clk) begin : monitor
        logic   evt, e_fe, e_ov;
        frame_t f;
        evt  = 1'b0;
        e_fe = 1'b0;
        e_ov = 1'b0;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            pend.delete();
        end else begin
            n_fe += int'(framing_error);
            n_ov += int'(overrun);
            if (pend.size() > 0 && pend[0].done <= cyc) begin
                f   = pend.pop_front();
                evt = 1'b1;
                if (!f.stop)
                    e_fe = 1'b1;
                else if (m_valid && !rdy_edge)
                    e_ov = 1'b1;
                else begin
                    m_valid = 1'b1;
                    m_data  = f.d;
                end
            end
            if (!(evt && f.stop && !e_ov) && m_valid && rdy_edge)
                m_valid = 1'b0;
        end
        if (evt || valid !== m_valid || (m_valid && data !== m_data) ||
            framing_error !== e_fe || overrun !== e_ov) begin
            check("valid", 32'(valid), 32'(m_valid));
            if (m_valid) check("data", 32'(data), 32'(m_data));
            check("framing_error", 32'(framing_error), 32'(e_fe));
            check("overrun", 32'(overrun), 32'(e_ov));
        end
        rdy_edge = ready;
    end

    initial begin : consumer
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 so frames can be chained with zero idle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned cpb);
        frame_t     f;
        logic [9:0] bits;
        bits   = {stop, d, 1'b0};
        f.done = cyc + LAT;
        f.d    = d;
        f.stop = stop;
        pend.push_back(f);
        last_done = f.done;
        for (int unsigned i = 0; i < 10; i++) begin
            rx = bits[i];
            idle(cpb);
        end
        rx = 1'b1;
    endtask

    initial begin : timeout
        #1_500_000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int         fe0, ov0;
        logic [9:0] bits;
        logic [7:0] d;
        bit         bad;
        int unsigned c;

        #1 reset = 1'b1;
        idle(3);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_ferr", 32'(framing_error), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        idle(10);

        // Basic bytes, back to back, consumer always ready.
        ready = 1'b1;
        send_frame(8'h55, 1'b1, CPB);
        send_frame(8'hA3, 1'b1, CPB);
        idle(20);
        check("basic_no_ferr", 32'(n_fe), 32'd0);
        check("basic_no_ovr", 32'(n_ov), 32'd0);

        // Short low glitch must be rejected.
        fe0 = n_fe;
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(300);
        check("glitch_valid", 32'(valid), 32'd0);
        check("glitch_ferr", 32'(n_fe), 32'(fe0));

        // Stop bit held low.
        fe0 = n_fe;
        send_frame(8'h3C, 1'b0, CPB);
        idle(2 * CPB);
        check("frame_err_count", 32'(n_fe), 32'(fe0 + 1));
        check("frame_err_valid", 32'(valid), 32'd0);

        // Backpressure: second byte overruns, first is held.
        ready = 1'b0;
        ov0 = n_ov;
        send_frame(8'h11, 1'b1, CPB);
        send_frame(8'h22, 1'b1, CPB);
        idle(10);
        check("bp_valid", 32'(valid), 32'd1);
        check("bp_data", 32'(data), 32'h11);
        check("bp_ovr_count", 32'(n_ov), 32'(ov0 + 1));
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        check("bp_drain_valid", 32'(valid), 32'd0);

        // Consume and load on the same edge.
        ov0 = n_ov;
        send_frame(8'h11, 1'b1, CPB);
        fork
            send_frame(8'h22, 1'b1, CPB);
            begin
                #2;
                while (cyc < last_done - 1) begin
                    @(posedge clk);
                    #1;
                end
                ready = 1'b1;
                idle(1);
                ready = 1'b0;
            end
        join
        idle(10);
        check("simul_ovr_count", 32'(n_ov), 32'(ov0));
        check("simul_valid", 32'(valid), 32'd1);
        check("simul_data", 32'(data), 32'h22);

        // Reset in the middle of data bit 4 of 0xF0, with a byte still held.
        bits = {1'b1, 8'hF0, 1'b0};
        for (int unsigned i = 0; i < 5; i++) begin
            rx = bits[i];
            idle(CPB);
        end
        rx = bits[5];
        idle(CPB / 2);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_ferr", 32'(framing_error), 32'd0);
        check("midrst_ovr", 32'(overrun), 32'd0);
        rx = 1'b1;
        idle(5);
        reset = 1'b0;
        idle(3 * CPB);
        send_frame(8'h7E, 1'b1, CPB);
        idle(5);
        check("post_rst_valid", 32'(valid), 32'd1);
        check("post_rst_data", 32'(data), 32'h7E);
        ready = 1'b1;
        idle(5);

        // Baud tolerance, -2% then +2%, back to back.
        fe0 = n_fe;
        send_frame(8'h96, 1'b1, CPB - 4);
        send_frame(8'h96, 1'b1, CPB + 4);
        idle(20);
        check("tol_no_ferr", 32'(n_fe), 32'(fe0));

        // Random frames, random consumer, occasional bad stop bit.
        rand_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            c   = bad ? CPB : $urandom_range(CPB - 4, CPB + 4);
            send_frame(d, !bad, c);
            if (bad)
                idle(CPB + $urandom_range(0, 20));
            else if ($urandom_range(0, 2) != 0)
                idle($urandom_range(1, 40));
        end
        rand_rdy = 1'b0;
        idle(20);
        ready = 1'b1;
        idle(5);
        check("final_valid", 32'(valid), 32'd0);
        check("final_pending", 32'(pend.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the board's UART link: 115200 baud, 8 data bits, no parity, 1 stop bit, LSB first, at 100 MHz. It is the receive-side counterpart of the existing transmitter. It recovers bytes from the `rx` pin and presents each one on a one-entry valid/ready output, which feeds the byte store/echo logic upstream of the transmitter. Line errors are reported as single-cycle pulses and never stall the receiver.

## Interface
- `CLK_PER_BIT`, default 868 (100000000/115200): clock cycles per bit. Must be ≥ 4.
- `HALF_BIT`, default `CLK_PER_BIT/2` (434): cycles from start-edge detection to the start-bit sample.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous to `clk`. Idle level is 1.
- `data`  out  8  received byte. Valid only while `valid`=1.
- `valid`  out  1  the holding register contains an unconsumed byte.
- `ready`  in  1  the consumer accepts `data` on a cycle where `valid`&&`ready`.
- `framing_error`  out  1  one-cycle pulse: the stop bit was sampled as 0.
- `overrun`  out  1  one-cycle pulse: a good frame completed while the holding register was full.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Bit-timing counter.** One down-counter of width `$clog2(CLK_PER_BIT)`. In every non-IDLE state it decrements each cycle. "Tick" means counter==0; on a tick the state samples `rx_s` and reloads the counter.
- **State machine:** IDLE, START, DATA, STOP.
  - **IDLE:** if `rx_s`==0, load counter=`HALF_BIT`-1 and go to START. Otherwise stay in IDLE.
  - **START** (tick, at mid start bit): if `rx_s`==1, treat it as a glitch/false start and return to IDLE with no output. If `rx_s`==0, load counter=`CLK_PER_BIT`-1, set bit_idx=0 and go to DATA.
  - **DATA** (tick): write `rx_s` into shift[bit_idx]. If bit_idx==7, go to STOP; otherwise increment bit_idx. Reload the counter to `CLK_PER_BIT`-1 on every tick.
  - **STOP** (tick, mid stop bit): always return to IDLE. This allows a following start edge to be detected from the second half of the stop bit onward.
    - If `rx_s`==1 and the holding register is free (or is being consumed this same cycle), load `data`<=shift and set `valid`<=1.
    - If `rx_s`==1 and `valid`&&!`ready`, pulse `overrun`. The new byte is dropped, and `data` and `valid` are unchanged.
    - If `rx_s`==0, pulse `framing_error` and drop the byte. The next IDLE cycle re-arms on the next 0, so a break condition produces repeated framing errors, one per frame time.
- **Output handshake.**
  - `data` is stable while `valid`=1.
  - A transfer occurs on a rising edge with `valid`&&`ready`.
  - `valid` drops the following cycle unless a new byte loads on that same edge. Load has priority, so `valid` stays 1 with the new `data`.
  - `ready` is ignored while `valid`=0.
- **Reset.** Assertion takes effect immediately, including in mid-frame:
  - state=IDLE; counter and bit_idx = 0; shift = 0;
  - `data`=0, `valid`=0, `framing_error`=0, `overrun`=0;
  - synchronizer flops = 1.
  - After release, a frame already in progress on the line is only picked up at its next 1→0 transition. A partial frame may therefore be received as garbage or raise a framing error; no other side effect is allowed.

## Timing
- Pin-to-`rx_s` latency: 2 cycles.
- Let T be the first cycle with `rx_s`==0 while in IDLE.
  - Start bit is sampled at T+434.
  - Data bit k is sampled at T+434+868·(k+1).
  - Stop bit is sampled at T+8246.
  - `valid`, `framing_error` or `overrun` become visible at T+8247, which is about 8249 cycles after the pin edge.
- All outputs are registered. Both error pulses are exactly 1 cycle wide, and they never assert in the same cycle.
- Tolerated baud mismatch: at least ±2% (sampling error at bit 9 stays under half a bit).
- Throughput: back-to-back frames with a 1-bit stop and zero idle are received with no loss, provided the consumer drains within one frame time (8680 cycles).

## Test plan
- **Basic byte:** send 0x55 and then 0xA3 at 868 cycles/bit with `ready`=1 → `valid` pulses 1 cycle with `data`=0x55 and then 0xA3, at T+8247 of each frame. No error pulses.
- **Glitch and framing:**
  - Drive `rx` low for 200 cycles, then high → no `valid`, no error, FSM back in IDLE.
  - Send 0x3C with the stop bit held 0 → `framing_error` is high for exactly 1 cycle and `valid` stays 0.
- **Backpressure:** with `ready`=0, send 0x11 then 0x22 back-to-back → `valid`=1 and `data`=0x11 throughout. A 1-cycle `overrun` pulse occurs at the second frame's stop sample. Then raising `ready` for 1 cycle → `valid`=0 on the next cycle.
- **Simultaneous consume and load:** hold 0x11 with `ready`=0, then assert `ready` exactly on the cycle the 0x22 frame completes → no `overrun`, `valid` stays 1, and `data`=0x22 on the next cycle.
- **Reset mid-frame:** assert `reset` during data bit 4 of a 0xF0 frame → all outputs 0 immediately. After release and a clean idle line, 0x7E is received correctly.
- **Baud tolerance:** send 0x96 at 851 and then at 885 cycles/bit, in back-to-back frames → both are received as 0x96 with no errors.
